// File: rtl/fp64_iter_mult.sv
// rtl/fp64_iter_mult.sv - multi-cycle IEEE-754 binary64 multiplier with shift-add mantissa datapath
module fp64_iter_mult #(
    parameter int FLEN      = 64,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic [FLEN-1:0] res,
    output logic            down_valid,
    output logic            busy,
    output logic            error
);
    localparam int ITERS = 54 / STEP_BITS;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int SW    = 109 + STEP_BITS;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND} state_t;

    state_t             state_q, state_d;
    logic [FLEN-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [53:0]        mcand_q, mcand_d, mplier_q, mplier_d;
    logic [107:0]       acc_q, acc_d;
    logic signed [12:0] exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               spec_q, spec_d, spec_err_q, spec_err_d;
    logic [63:0]        spec_res_q, spec_res_d;
    logic [52:0]        mant_q, mant_d;
    logic               guard_q, guard_d, sticky_q, sticky_d;

    logic [10:0]        a_exp, b_exp;
    logic [51:0]        a_frac, b_frac;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               accept;
    logic [53+STEP_BITS:0] part;
    logic [SW-1:0]      sum;

    logic [53:0]        mant_r;
    logic signed [12:0] exp_r;
    logic [51:0]        frac_r;
    logic [63:0]        packed_res;
    logic               packed_err;
    logic               unused_bits;

    assign a_exp  = a_q[62:52];
    assign b_exp  = b_q[62:52];
    assign a_frac = a_q[51:0];
    assign b_frac = b_q[51:0];
    assign a_nan  = (a_exp == 11'h7FF) && (a_frac != '0);
    assign b_nan  = (b_exp == 11'h7FF) && (b_frac != '0);
    assign a_inf  = (a_exp == 11'h7FF) && (a_frac == '0);
    assign b_inf  = (b_exp == 11'h7FF) && (b_frac == '0);
    // Subnormals are flushed: any zero exponent counts as zero.
    assign a_zero = (a_exp == 11'h000);
    assign b_zero = (b_exp == 11'h000);

    assign down_valid = (state_q == S_ROUND);
    assign busy       = (state_q != S_IDLE) && (state_q != S_ROUND);
    assign accept     = up_valid && !busy;
    assign res        = down_valid ? packed_res : res_q;
    assign error      = down_valid && packed_err;

    assign unused_bits = ^{sum[SW-1], sum[STEP_BITS-1:0], acc_q[107:106]};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        spec_d     = spec_q;
        spec_err_d = spec_err_q;
        spec_res_d = spec_res_q;
        mant_d     = mant_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        part       = '0;
        sum        = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d   = a_q[63] ^ b_q[63];
                exp_d    = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 13'sd1023;
                mcand_d  = {2'b01, a_frac};
                mplier_d = {2'b01, b_frac};
                acc_d    = '0;
                cnt_d    = CW'(ITERS - 1);
                spec_d     = 1'b1;
                spec_err_d = 1'b1;
                spec_res_d = QNAN;
                if (a_nan || b_nan) begin
                    spec_res_d = QNAN;
                end else if (a_inf || b_inf) begin
                    spec_res_d = (a_zero || b_zero) ? QNAN : {a_q[63] ^ b_q[63], 11'h7FF, 52'h0};
                end else if (a_zero || b_zero) begin
                    spec_res_d = {a_q[63] ^ b_q[63], 63'h0};
                    spec_err_d = 1'b0;
                end else begin
                    spec_d     = 1'b0;
                    spec_err_d = 1'b0;
                end
                state_d = S_MUL;
            end
            S_MUL: begin
                // Add the partial product at the top, then shift the whole accumulator right.
                part     = (54 + STEP_BITS)'(mcand_q) * (54 + STEP_BITS)'(mplier_q[STEP_BITS-1:0]);
                sum      = SW'(acc_q) + SW'({part, 54'h0});
                acc_d    = sum[STEP_BITS +: 108];
                mplier_d = mplier_q >> STEP_BITS;
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_NORM: begin
                if (acc_q[105]) begin
                    mant_d   = acc_q[105:53];
                    guard_d  = acc_q[52];
                    sticky_d = |acc_q[51:0];
                    exp_d    = exp_q + 13'sd1;
                end else begin
                    mant_d   = acc_q[104:52];
                    guard_d  = acc_q[51];
                    sticky_d = |acc_q[50:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                res_d = packed_res;
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_UNPACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mant_r     = {1'b0, mant_q} + {53'h0, guard_q & (sticky_q | mant_q[0])};
        exp_r      = mant_r[53] ? exp_q + 13'sd1 : exp_q;
        frac_r     = mant_r[53] ? 52'h0 : mant_r[51:0];
        packed_res = {sign_q, exp_r[10:0], frac_r};
        packed_err = 1'b0;
        if (spec_q) begin
            packed_res = spec_res_q;
            packed_err = spec_err_q;
        end else if (exp_r >= 13'sd2047) begin
            packed_res = {sign_q, 11'h7FF, 52'h0};
            packed_err = 1'b1;
        end else if (exp_r <= 13'sd0) begin
            packed_res = {sign_q, 63'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_err_q <= 1'b0;
            spec_res_q <= '0;
            mant_q     <= '0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_err_q <= spec_err_d;
            spec_res_q <= spec_res_d;
            mant_q     <= mant_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
        end
    end
endmodule

// File: doc/fp64_iter_mult.md
Name: fp64_iter_mult

Overview:
- Multi-cycle FP64 multiplier that sits on the responder side of the FPU operation handshake (up_valid/a/b in; res/down_valid/busy/error out).
- Drop-in multiply unit for FSM-based FP datapaths such as discriminant and polynomial evaluators.
- Uses an iterative shift-add mantissa multiplier to trade latency for area.

Parameters:
- FLEN, 64, operand width. Only 64 is supported: IEEE-754 binary64.
- STEP_BITS, 1, multiplier bits consumed per iteration. Legal values are 1, 2, 3, 6, 9 (each divides 54).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (rst==0 resets)
- up_valid  input  1  operation request
- a  input  FLEN  operand A
- b  input  FLEN  operand B
- res  output  FLEN  product; valid while down_valid=1, then held until the next down_valid
- down_valid  output  1  one-cycle result strobe
- busy  output  1  operation in flight; requests are ignored while this is high
- error  output  1  exception flag; qualified by down_valid, 0 otherwise

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE, res=0, down_valid=0, busy=0, error=0. An in-flight operation is aborted and produces no down_valid.
- Accept rule: the unit accepts when up_valid && !busy. a and b are captured on that edge and do not need to be held afterwards. up_valid while busy is dropped, with no queueing.
- Latency: LAT = 54/STEP_BITS + 3 cycles. The default is 57.
  - Accept edge is T0. down_valid is high in cycle T0+LAT.
  - Latency is fixed for every input class, including specials.
- busy is 1 from cycle T0+1 through T0+LAT-1. It is 0 in the down_valid cycle, so up_valid in that cycle is accepted (back-to-back issue).
- FSM states and transitions:
  - IDLE -> UNPACK on accept.
  - UNPACK (1 cycle): split sign, exponent and mantissa; insert the hidden bit; classify each operand as zero, normal, Inf or NaN; pad the mantissa to 54 bits. Go to MUL.
  - MUL (54/STEP_BITS cycles): shift-add STEP_BITS multiplier bits per cycle into a 108-bit accumulator. Iteration counter counts down to 0, then go to NORM.
  - NORM (1 cycle): if product bit 105 is set, shift right by 1 and increment the exponent. Form the guard bit and sticky bit. Go to ROUND.
  - ROUND (1 cycle): round-to-nearest-even. A mantissa carry-out renormalises and increments the exponent. Pack the result, drive down_valid=1, go to IDLE.
- Arithmetic rules:
  - sign = sa ^ sb.
  - Exponent is computed as ea + eb - 1023 in a 13-bit signed width.
  - Subnormal inputs are flushed to zero.
  - A result with biased exponent <= 0 becomes signed zero, error=0.
  - A result with biased exponent >= 2047 after rounding becomes signed Inf, error=1.
- Special cases (the MUL iterations still run, and the result is overridden in ROUND):
  - Either operand NaN: res=0x7FF8_0000_0000_0000, error=1.
  - Inf x 0: res=0x7FF8_0000_0000_0000, error=1.
  - Inf x nonzero: res = signed Inf, error=1.
  - 0 x finite: res = signed zero, error=0.
- error is held at 0 whenever down_valid=0.

Test Plan:
- 2.0 x 3.0: a=0x4000_0000_0000_0000, b=0x4008_0000_0000_0000 -> res=0x4018_0000_0000_0000, error=0, down_valid exactly 57 cycles after accept, busy high for 56 cycles.
- Rounding: a=b=0x3FF0_0000_0000_0001 -> res=0x3FF0_0000_0000_0002 (RNE, sticky set). Also 1.5 x 1.5 -> 0x4002_0000_0000_0000.
- Exceptions:
  - NaN x 1.0 -> 0x7FF8_0000_0000_0000, error=1.
  - Inf x 0 -> same qNaN, error=1.
  - 0x7FEF_FFFF_FFFF_FFFF x 2.0 -> 0x7FF0_0000_0000_0000, error=1.
  - -0.0 x 5.0 -> 0x8000_0000_0000_0000, error=0.
- Underflow: 0x0010_0000_0000_0000 x 0.5 -> res=0x0000_0000_0000_0000, error=0. A subnormal input x 2.0 -> 0.
- Handshake:
  - up_valid held high continuously with varying operands -> accepts occur only in the IDLE/down_valid cycles, one result every 57 cycles.
  - A request issued in the down_valid cycle is accepted.
  - up_valid pulses during busy produce no extra results.
- Reset mid-operation: drop rst to 0 at T0+20 for 1 cycle -> busy=0, down_valid never asserted for that operation; a new request 1 cycle after reset completes correctly.
